// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the button debouncer bank.
// Provides the per-channel state enum and the counter width helper.
package debounce_pkg;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    // Width able to hold 0..max(a,b) inclusive.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel -- synchroniser, stability FSM,
// hold counter and registered pulses.
// Ports: clk, rst (sync, active-high), click_in (raw async line),
//        click_out (clean level), press_pulse, release_pulse, hold_pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 10,
    parameter int HOLD_CYCLES   = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic click_in,
    output logic click_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   commit;

    assign s = sync[SYNC_STAGES-1];

    // Stable window has fully elapsed: click_out takes s on this edge.
    assign commit = (state == COUNT) && (s != click_out) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], click_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            click_out     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s != click_out) begin
                        state <= COUNT;
                        cnt   <= LOAD;
                    end else begin
                        cnt <= '0;
                    end
                end
                COUNT: begin
                    if (s == click_out) begin
                        // Bounce back: window restarts on the next change.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (commit) begin
                        click_out     <= s;
                        press_pulse   <= s;
                        release_pulse <= ~s;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    generate
        if (HOLD_CYCLES == 0) begin : g_no_hold
            assign hold_pulse = 1'b0;
        end else begin : g_hold
            localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
            localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD_CYCLES - 1);

            logic [CNT_W-1:0] hcnt;

            // hcnt is zero on the press edge (click_out still 0), so it
            // reaches HOLD_CYCLES-1 exactly HOLD_CYCLES-1 edges later.
            // A release committing on the same edge suppresses the pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hcnt       <= '0;
                    hold_pulse <= 1'b0;
                end else begin
                    hold_pulse <= click_out && !commit && (hcnt == HOLD_M1);
                    if (!click_out) begin
                        hcnt <= '0;
                    end else if (hcnt != HOLD_MAX) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/debouncer_bank.sv
// debouncer_bank: CHANNELS independent button debouncers plus any_press.
// Ports: clk, rst (sync, active-high), click_in[CHANNELS], click_out,
//        press_pulse, release_pulse, hold_pulse (per channel), any_press.
module debouncer_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 10,
    parameter int HOLD_CYCLES   = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] click_in,
    output logic [CHANNELS-1:0] click_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic                any_press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .click_in     (click_in[i]),
            .click_out    (click_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .hold_pulse   (hold_pulse[i])
        );
    end

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_debouncer_bank.sv
// tb_debouncer_bank: directed and randomised checks of debouncer_bank
// against a run-length behavioural model.
module tb_debouncer_bank;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int ST = 10;
    localparam int HC = 20;

    logic          clk;
    logic          rst;
    logic [CH-1:0] click_in;
    logic [CH-1:0] click_out;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] hold_pulse;
    logic          any_press;

    int n_cmp = 0;
    int n_bad = 0;

    debouncer_bank #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(ST),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .click_in     (click_in),
        .click_out    (click_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse),
        .any_press    (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: s is the input seen SS edges ago; the level
    // flips once s has differed from it on ST+1 consecutive edges.
    bit            q[CH][$];
    bit            lvl[CH];
    int            run[CH];
    int            age[CH];
    bit            mdl_valid = 1'b0;
    logic [CH-1:0] e_out   = '0;
    logic [CH-1:0] e_press = '0;
    logic [CH-1:0] e_rel   = '0;
    logic [CH-1:0] e_hold  = '0;

    task automatic model_step();
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                q[c] = {};
                for (int k = 0; k < SS; k++) q[c].push_back(1'b0);
                lvl[c] = 1'b0;
                run[c] = 0;
                age[c] = 0;
            end
            e_out = '0; e_press = '0; e_rel = '0; e_hold = '0;
            mdl_valid = 1'b1;
        end else if (mdl_valid) begin
            for (int c = 0; c < CH; c++) begin
                bit s, old, p, r, h;
                s = q[c].pop_front();
                q[c].push_back(click_in[c]);
                old = lvl[c];
                p = 1'b0; r = 1'b0; h = 1'b0;
                if (s != lvl[c]) run[c]++;
                else run[c] = 0;
                if (run[c] == ST + 1) begin
                    lvl[c] = s;
                    run[c] = 0;
                    p = s;
                    r = !s;
                end
                if (p) age[c] = 0;
                else if (old) begin
                    age[c]++;
                    if (age[c] == HC && !r) h = 1'b1;
                end
                e_out[c] = lvl[c];
                e_press[c] = p;
                e_rel[c] = r;
                e_hold[c] = h;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mdl_valid) begin
            chk("m_click_out", 32'(click_out), 32'(e_out));
            chk("m_press", 32'(press_pulse), 32'(e_press));
            chk("m_release", 32'(release_pulse), 32'(e_rel));
            chk("m_hold", 32'(hold_pulse), 32'(e_hold));
            chk("m_any_press", 32'(any_press), 32'(|e_press));
        end
    end

    int remain[CH];
    bit seen;
    bit seen2;

    initial begin
        rst = 1'b1;
        click_in = '0;
        tick(3);
        chk("reset_outs",
            32'({click_out, press_pulse, release_pulse, hold_pulse, any_press}), 0);
        rst = 1'b0;
        tick(4);

        // clean press on ch0
        click_in[0] = 1'b1;
        tick(12);
        chk("press_edge12_out", 32'(click_out), 32'(4'b0000));
        tick(1);
        chk("press_edge13_out", 32'(click_out), 32'(4'b0001));
        chk("press_edge13_pulse", 32'(press_pulse), 32'(4'b0001));
        chk("press_edge13_any", 32'(any_press), 1);
        tick(1);
        chk("press_one_cycle", 32'(press_pulse), 0);

        // hold fires HC edges after the press edge
        tick(18);
        chk("hold_early", 32'(hold_pulse), 0);
        tick(1);
        chk("hold_fire", 32'(hold_pulse), 32'(4'b0001));
        tick(1);
        chk("hold_once", 32'(hold_pulse), 0);
        tick(20);

        // release
        click_in[0] = 1'b0;
        tick(12);
        chk("release_edge12_out", 32'(click_out), 32'(4'b0001));
        tick(1);
        chk("release_edge13_pulse", 32'(release_pulse), 32'(4'b0001));
        chk("release_edge13_out", 32'(click_out), 0);
        tick(3);

        // short press: pressed, released before the hold point
        click_in[0] = 1'b1;
        seen = 1'b0; seen2 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (hold_pulse[0]) seen = 1'b1;
            if (press_pulse[0]) seen2 = 1'b1;
        end
        click_in[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (hold_pulse[0]) seen = 1'b1;
            if (press_pulse[0]) seen2 = 1'b1;
        end
        chk("short_no_hold", 32'(seen), 0);
        chk("short_pressed", 32'(seen2), 1);

        // bounce on ch1
        seen = 1'b0;
        repeat (2) begin
            click_in[1] = 1'b1;
            repeat (5) begin tick(1); if (click_out[1]) seen = 1'b1; end
            click_in[1] = 1'b0;
            repeat (3) begin tick(1); if (click_out[1]) seen = 1'b1; end
        end
        chk("bounce_reject", 32'(seen), 0);
        click_in[1] = 1'b1;
        tick(12);
        chk("bounce_edge12_out", 32'(click_out), 0);
        tick(1);
        chk("bounce_edge13_pulse", 32'(press_pulse), 32'(4'b0010));
        click_in[1] = 1'b0;
        tick(16);

        // simultaneous ch0 and ch3
        click_in = 4'b1001;
        tick(13);
        chk("simul_press", 32'(press_pulse), 32'(4'b1001));
        chk("simul_any", 32'(any_press), 1);
        tick(1);
        chk("simul_any_drop", 32'(any_press), 0);
        click_in = '0;
        tick(16);

        // reset mid-count
        click_in[3] = 1'b1;
        tick(15);
        chk("pre_rst_out", 32'(click_out), 32'(4'b1000));
        click_in[2] = 1'b1;
        tick(7);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_outs",
            32'({click_out, press_pulse, release_pulse, hold_pulse, any_press}), 0);
        rst = 1'b0;
        tick(12);
        chk("post_rst_edge12", 32'(press_pulse), 0);
        tick(1);
        chk("post_rst_edge13", 32'(press_pulse), 32'(4'b1100));
        click_in = '0;
        tick(16);

        // width boundary: ST cycles rejected, ST+1 accepted
        click_in[1] = 1'b1;
        tick(ST);
        click_in[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (click_out[1]) seen = 1'b1;
        end
        chk("narrow_reject", 32'(seen), 0);
        click_in[1] = 1'b1;
        tick(ST + 1);
        click_in[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (press_pulse[1]) seen = 1'b1;
        end
        chk("min_width_accept", 32'(seen), 1);
        tick(10);

        // randomised traffic, model checked every cycle
        for (int c = 0; c < CH; c++) remain[c] = $urandom_range(1, 20);
        for (int n = 0; n < 5000; n++) begin
            tick(1);
            rst = ($urandom_range(0, 799) == 0);
            for (int c = 0; c < CH; c++) begin
                remain[c]--;
                if (remain[c] <= 0) begin
                    click_in[c] = ~click_in[c];
                    remain[c] = ($urandom_range(0, 3) == 0)
                        ? $urandom_range(20, 60) : $urandom_range(1, 16);
                end
            end
        end
        rst = 1'b0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
